// File: rtl/sh_divu_gen_if.sv
// Operand/result bus of the iterative divide unit: the register wrapper is master, the divider is slave.
interface sh_divu_gen_if #(
    parameter int W = 32
) ();
    logic         CE;
    logic         START;
    logic         ABORT;
    logic         SIGNED;
    logic         LONG;
    logic [W-1:0] DVDH;
    logic [W-1:0] DVDL;
    logic [W-1:0] DVSR;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] QUOT;
    logic [W-1:0] REM;
    logic         OVF;
    logic         DZ;

    modport master (
        output CE, START, ABORT, SIGNED, LONG, DVDH, DVDL, DVSR,
        input  BUSY, DONE, QUOT, REM, OVF, DZ
    );

    modport slave (
        input  CE, START, ABORT, SIGNED, LONG, DVDH, DVDL, DVSR,
        output BUSY, DONE, QUOT, REM, OVF, DZ
    );
endinterface

// File: rtl/sh_divu_gen.sv
// Iterative restoring divider: W- or 2W-bit dividend by W-bit divisor, signed or unsigned,
// one quotient bit per CE cycle, with overflow / divide-by-zero detection and optional saturation.
module sh_divu_gen #(
    parameter int W          = 32,
    parameter bit SAT_ON_OVF = 1'b1,
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic         CLK,
    input logic         RST_N,
    sh_divu_gen_if.slave bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;
    state_t state, state_nxt;

    // Operands latched on the accepting edge
    logic         sgn_q, lng_q;
    logic [W-1:0] dvdh_q, dvdl_q, dvsr_q;

    // Iteration datapath
    logic [W:0]    rem_q, dsr_q;
    logic [W-1:0]  lo_q, quot_q;
    logic [CW-1:0] cnt_q;
    logic          dvd_neg_q, dsr_neg_q, ovf_pend_q, dz_pend_q;

    // Architectural results
    logic [W-1:0] quot_r, rem_r;
    logic         ovf_r, dz_r;

    logic [2*W-1:0] ld_dvd;
    logic [2*W:0]   ld_abs_dvd;
    logic [W:0]     ld_abs_dsr;
    logic           ld_dvd_neg, ld_dsr_neg, ld_dz, ld_hi_ovf;
    logic [W+1:0]   trial;
    logic           fix_q_neg, rng_ovf;
    logic           res_ovf, res_dz, res_neg;
    logic [W-1:0]   res_quot, res_rem, sat_quot;
    logic           busy, done;

    always_comb begin
        if (lng_q)
            ld_dvd = {dvdh_q, dvdl_q};
        else if (sgn_q)
            ld_dvd = {{W{dvdl_q[W-1]}}, dvdl_q};
        else
            ld_dvd = {{W{1'b0}}, dvdl_q};
        ld_dvd_neg = sgn_q & ld_dvd[2*W-1];
        ld_dsr_neg = sgn_q & dvsr_q[W-1];
        ld_abs_dvd = ld_dvd_neg ? ({1'b0, ~ld_dvd} + (2*W+1)'(1)) : {1'b0, ld_dvd};
        ld_abs_dsr = ld_dsr_neg ? ({1'b0, ~dvsr_q} + (W+1)'(1)) : {1'b0, dvsr_q};
        ld_dz      = (dvsr_q == '0);
        // A high part >= divisor means the quotient cannot fit in W bits
        ld_hi_ovf  = lng_q & (ld_abs_dvd[2*W:W] >= ld_abs_dsr);
    end

    assign trial = {rem_q, lo_q[W-1]} - {1'b0, dsr_q};

    always_comb begin
        fix_q_neg = dvd_neg_q ^ dsr_neg_q;
        rng_ovf   = sgn_q & (fix_q_neg ? (quot_q[W-1] & (|quot_q[W-2:0])) : quot_q[W-1]);
        // Early exit finishes straight from LOAD, so flags come from the LOAD-time decode
        if (state == S_LOAD) begin
            res_ovf = 1'b1;
            res_dz  = ld_dz;
            res_neg = ld_dvd_neg ^ ld_dsr_neg;
        end else begin
            res_ovf = ovf_pend_q | rng_ovf;
            res_dz  = dz_pend_q;
            res_neg = fix_q_neg;
        end
        res_quot = fix_q_neg ? (~quot_q + W'(1)) : quot_q;
        res_rem  = dvd_neg_q ? (~rem_q[W-1:0] + W'(1)) : rem_q[W-1:0];
        sat_quot = sgn_q ? {res_neg, {(W-1){~res_neg}}} : '1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= S_IDLE;
        else if (bus.CE)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.START && !bus.ABORT) state_nxt = S_LOAD;
            S_LOAD: begin
                if (bus.ABORT)
                    state_nxt = S_IDLE;
                else if (EARLY_EXIT && (ld_dz || ld_hi_ovf))
                    state_nxt = S_DONE;
                else
                    state_nxt = S_ITER;
            end
            S_ITER: begin
                if (bus.ABORT)
                    state_nxt = S_IDLE;
                else if (cnt_q == CW'(W-1))
                    state_nxt = S_FIX;
            end
            S_FIX:  state_nxt = bus.ABORT ? S_IDLE : S_DONE;
            S_DONE: state_nxt = (bus.START && !bus.ABORT) ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_LOAD) || (state == S_ITER) || (state == S_FIX);
        done = (state == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sgn_q      <= 1'b0;
            lng_q      <= 1'b0;
            dvdh_q     <= '0;
            dvdl_q     <= '0;
            dvsr_q     <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            lo_q       <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
            dvd_neg_q  <= 1'b0;
            dsr_neg_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            dz_pend_q  <= 1'b0;
            quot_r     <= '0;
            rem_r      <= '0;
            ovf_r      <= 1'b0;
            dz_r       <= 1'b0;
        end else if (bus.CE) begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (state_nxt == S_LOAD) begin
                        sgn_q  <= bus.SIGNED;
                        lng_q  <= bus.LONG;
                        dvdh_q <= bus.DVDH;
                        dvdl_q <= bus.DVDL;
                        dvsr_q <= bus.DVSR;
                        ovf_r  <= 1'b0;
                        dz_r   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    rem_q      <= ld_abs_dvd[2*W:W];
                    lo_q       <= ld_abs_dvd[W-1:0];
                    dsr_q      <= ld_abs_dsr;
                    quot_q     <= '0;
                    cnt_q      <= '0;
                    dvd_neg_q  <= ld_dvd_neg;
                    dsr_neg_q  <= ld_dsr_neg;
                    ovf_pend_q <= ld_dz | ld_hi_ovf;
                    dz_pend_q  <= ld_dz;
                end
                S_ITER: begin
                    if (!trial[W+1])
                        rem_q <= trial[W:0];
                    else
                        rem_q <= {rem_q[W-1:0], lo_q[W-1]};
                    quot_q <= {quot_q[W-2:0], ~trial[W+1]};
                    lo_q   <= {lo_q[W-2:0], 1'b0};
                    cnt_q  <= cnt_q + CW'(1);
                end
                default: ;
            endcase

            if (state_nxt == S_DONE) begin
                ovf_r <= res_ovf;
                dz_r  <= res_dz;
                if (!res_ovf) begin
                    quot_r <= res_quot;
                    rem_r  <= res_rem;
                end else if (SAT_ON_OVF) begin
                    quot_r <= sat_quot;
                    rem_r  <= '0;
                end
            end
        end
    end

    assign bus.BUSY = busy;
    assign bus.DONE = done;
    assign bus.QUOT = quot_r;
    assign bus.REM  = rem_r;
    assign bus.OVF  = ovf_r;
    assign bus.DZ   = dz_r;
endmodule

// File: tb/tb_sh_divu_gen.sv
// Scoreboard bench for sh_divu_gen: three instances (W=32 early-exit, W=32 full-run, W=16).
module tb_sh_divu_gen;
    logic        CLK;
    logic        RST_N;
    logic        ce;
    bit          ce_tog;
    logic [2:0]  start;
    logic        abort, sgn, lng;
    logic [31:0] dvdh, dvdl, dvsr;

    logic [31:0] o_quot [3];
    logic [31:0] o_rem  [3];
    logic [2:0]  o_busy, o_done, o_ovf, o_dz;

    typedef struct {
        logic [31:0] quot;
        logic [31:0] rem;
        logic        ovf;
        logic        dz;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb0[$], sb1[$], sb2[$];
    int   n_pass, n_total, cecnt, op_id;

    sh_divu_gen_if #(.W(32)) i0 ();
    sh_divu_gen_if #(.W(32)) i1 ();
    sh_divu_gen_if #(.W(16)) i2 ();

    assign i0.CE = ce;  assign i1.CE = ce;  assign i2.CE = ce;
    assign i0.START = start[0];  assign i1.START = start[1];  assign i2.START = start[2];
    assign i0.ABORT = abort;  assign i1.ABORT = abort;  assign i2.ABORT = abort;
    assign i0.SIGNED = sgn;  assign i1.SIGNED = sgn;  assign i2.SIGNED = sgn;
    assign i0.LONG = lng;  assign i1.LONG = lng;  assign i2.LONG = lng;
    assign i0.DVDH = dvdh;  assign i1.DVDH = dvdh;  assign i2.DVDH = dvdh[15:0];
    assign i0.DVDL = dvdl;  assign i1.DVDL = dvdl;  assign i2.DVDL = dvdl[15:0];
    assign i0.DVSR = dvsr;  assign i1.DVSR = dvsr;  assign i2.DVSR = dvsr[15:0];

    assign o_quot[0] = i0.QUOT;  assign o_quot[1] = i1.QUOT;  assign o_quot[2] = {16'h0, i2.QUOT};
    assign o_rem[0]  = i0.REM;   assign o_rem[1]  = i1.REM;   assign o_rem[2]  = {16'h0, i2.REM};
    assign o_busy = {i2.BUSY, i1.BUSY, i0.BUSY};
    assign o_done = {i2.DONE, i1.DONE, i0.DONE};
    assign o_ovf  = {i2.OVF,  i1.OVF,  i0.OVF};
    assign o_dz   = {i2.DZ,   i1.DZ,   i0.DZ};

    sh_divu_gen #(.W(32), .SAT_ON_OVF(1'b1), .EARLY_EXIT(1'b1)) u0 (.CLK(CLK), .RST_N(RST_N), .bus(i0));
    sh_divu_gen #(.W(32), .SAT_ON_OVF(1'b1), .EARLY_EXIT(1'b0)) u1 (.CLK(CLK), .RST_N(RST_N), .bus(i1));
    sh_divu_gen #(.W(16), .SAT_ON_OVF(1'b1), .EARLY_EXIT(1'b1)) u2 (.CLK(CLK), .RST_N(RST_N), .bus(i2));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // CE is either held high or toggled every cycle; CE edges are counted for latency checks
    initial begin
        ce = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            ce = ce_tog ? ~ce : 1'b1;
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            if (ce) cecnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL global timeout: got still running, expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic int sb_size(input int k);
        case (k)
            0: return sb0.size();
            1: return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic sb_push(input int k, input exp_t e);
        case (k)
            0: sb0.push_back(e);
            1: sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int k, output exp_t e);
        case (k)
            0: e = sb0.pop_front();
            1: e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
    endtask

    // Monitor: one scoreboard pop per DONE pulse
    initial begin
        exp_t       e;
        logic [2:0] seen;
        seen = '0;
        forever begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                if (o_done[k] && !seen[k]) begin
                    if (sb_size(k) == 0) begin
                        chk($sformatf("dut%0d unexpected DONE", k), 32'd1, 32'd0);
                    end else begin
                        sb_pop(k, e);
                        chk($sformatf("dut%0d op%0d quot", k, e.id), o_quot[k], e.quot);
                        chk($sformatf("dut%0d op%0d rem", k, e.id), o_rem[k], e.rem);
                        chk($sformatf("dut%0d op%0d ovf", k, e.id), {31'd0, o_ovf[k]}, {31'd0, e.ovf});
                        chk($sformatf("dut%0d op%0d dz", k, e.id), {31'd0, o_dz[k]}, {31'd0, e.dz});
                        chk($sformatf("dut%0d op%0d latency", k, e.id), 32'(cecnt - e.acc + 1), 32'(e.lat));
                    end
                end
                seen[k] = o_done[k];
            end
        end
    end

    task automatic issue(input int k, input bit s, input bit l, input logic [31:0] h, lo, d,
                         input bit track, input logic [31:0] eq, er, input bit eo, ez,
                         input int elat, output int acc);
        exp_t e;
        int   n;
        sgn = s; lng = l; dvdh = h; dvdl = lo; dvsr = d;
        start[k] = 1'b1;
        n = 0;
        do begin
            @(posedge CLK);
            n++;
        end while (!ce && n < 50);
        #1;
        start[k] = 1'b0;
        acc = cecnt;
        if (track) begin
            e.quot = eq; e.rem = er; e.ovf = eo; e.dz = ez;
            e.lat = elat; e.acc = acc; e.id = op_id++;
            sb_push(k, e);
        end
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while ((sb_size(k) != 0 || o_busy[k]) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk($sformatf("dut%0d completion within bound", k), {31'd0, n < 300}, 32'd1);
    endtask

    task automatic run(input int k, input bit s, input bit l, input logic [31:0] h, lo, d,
                       input logic [31:0] eq, er, input bit eo, ez, input int elat);
        int acc;
        issue(k, s, l, h, lo, d, 1'b1, eq, er, eo, ez, elat, acc);
        drain(k);
    endtask

    initial begin
        int acc, acc2, dedge, n;
        n_pass = 0; n_total = 0; cecnt = 0; op_id = 0; ce_tog = 1'b0;
        RST_N = 1'b0; start = '0; abort = 1'b0; sgn = 1'b0; lng = 1'b0;
        dvdh = '0; dvdl = '0; dvsr = '0;
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d reset flags", k), {28'd0, o_busy[k], o_done[k], o_ovf[k], o_dz[k]}, 32'd0);
            chk($sformatf("dut%0d reset quot", k), o_quot[k], 32'd0);
            chk($sformatf("dut%0d reset rem", k), o_rem[k], 32'd0);
        end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // W=32, early exit
        run(0, 0, 0, 32'h0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 35);
        run(0, 1, 0, 32'h0, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 0, 35);
        run(0, 1, 0, 32'h0, 32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 0, 0, 35);
        run(0, 1, 0, 32'h0, 32'd5, 32'd0, 32'h7FFF_FFFF, 32'd0, 1, 1, 2);
        run(0, 1, 1, 32'h0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 32'd0, 1, 0, 35);
        run(0, 1, 1, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 0, 35);
        run(0, 1, 0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1, 0, 35);
        run(0, 0, 1, 32'd7, 32'h0, 32'd5, 32'hFFFF_FFFF, 32'd0, 1, 0, 2);
        run(0, 0, 1, 32'd1, 32'h0, 32'd3, 32'h5555_5555, 32'd1, 0, 0, 35);
        run(0, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0, 0, 35);

        // CE toggling: latency still counted in CE edges
        ce_tog = 1'b1;
        run(0, 0, 0, 32'h0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 35);
        ce_tog = 1'b0;
        repeat (3) @(negedge CLK);

        // Abort at ITER cycle 10 of 1000/3: no DONE, previous 14/2 intact
        issue(0, 0, 0, 32'h0, 32'd1000, 32'd3, 1'b0, 32'h0, 32'h0, 0, 0, 0, acc);
        repeat (11) @(posedge CLK);
        #1 abort = 1'b1;
        @(posedge CLK);
        #1 abort = 1'b0;
        @(negedge CLK);
        chk("abort busy", {31'd0, o_busy[0]}, 32'd0);
        chk("abort quot held", o_quot[0], 32'd14);
        chk("abort rem held", o_rem[0], 32'd2);
        repeat (45) @(negedge CLK);
        run(0, 0, 0, 32'h0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0, 35);

        // Back-to-back: START held in the DONE cycle goes straight to LOAD
        issue(0, 0, 0, 32'h0, 32'd20, 32'd4, 1'b1, 32'd5, 32'd0, 0, 0, 35, acc);
        n = 0;
        while (!o_done[0] && n < 100) begin
            @(negedge CLK);
            n++;
        end
        dedge = cecnt;
        issue(0, 0, 0, 32'h0, 32'd21, 32'd5, 1'b1, 32'd4, 32'd1, 0, 0, 35, acc2);
        chk("b2b accept edge", 32'(acc2), 32'(dedge + 1));
        chk("b2b busy after accept", {31'd0, o_busy[0]}, 32'd1);
        drain(0);

        // START while BUSY is ignored
        issue(0, 0, 0, 32'h0, 32'd50, 32'd6, 1'b1, 32'd8, 32'd2, 0, 0, 35, acc);
        repeat (5) @(posedge CLK);
        #1;
        dvdl = 32'd7; dvsr = 32'd1; start[0] = 1'b1;
        repeat (3) @(posedge CLK);
        #1 start[0] = 1'b0;
        drain(0);

        // W=32 without early exit
        run(1, 1, 0, 32'h0, 32'd5, 32'd0, 32'h7FFF_FFFF, 32'd0, 1, 1, 35);
        run(1, 0, 1, 32'd7, 32'h0, 32'd5, 32'hFFFF_FFFF, 32'd0, 1, 0, 35);

        // W=16
        run(2, 0, 0, 32'h0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 19);
        run(2, 1, 0, 32'h0, -32'sd100, 32'd7, 32'h0000_FFF2, 32'h0000_FFFE, 0, 0, 19);
        run(2, 1, 0, 32'h0, 32'd100, -32'sd7, 32'h0000_FFF2, 32'd2, 0, 0, 19);
        run(2, 1, 0, 32'h0, 32'h0000_8000, 32'h0000_FFFF, 32'h0000_7FFF, 32'd0, 1, 0, 19);

        // Asynchronous reset mid-ITER clears outputs immediately
        issue(0, 0, 0, 32'h0, 32'd1000, 32'd3, 1'b0, 32'h0, 32'h0, 0, 0, 0, acc);
        repeat (10) @(posedge CLK);
        #3 RST_N = 1'b0;
        #1;
        chk("rst mid-op flags", {28'd0, o_busy[0], o_done[0], o_ovf[0], o_dz[0]}, 32'd0);
        chk("rst mid-op quot", o_quot[0], 32'd0);
        chk("rst mid-op rem", o_rem[0], 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
